// File: rtl/uart_console_bridge_pkg.sv
// rtl/uart_console_bridge_pkg.sv - shared widths, defaults and helpers for the UART console bridge
package uart_console_bridge_pkg;

    localparam int               CHAR_W          = 8;
    localparam logic [CHAR_W-1:0] NO_CHAR_DEFAULT = 8'hFF;
    localparam int               STAT_W          = 16;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value,
                                                 input logic              en);
        if (en && (value != {STAT_W{1'b1}}))
            return value + {{(STAT_W-1){1'b0}}, 1'b1};
        return value;
    endfunction

endpackage

// File: rtl/uart_console_bridge_sync_fifo.sv
// rtl/uart_console_bridge_sync_fifo.sv - synchronous FIFO with separate occupancy counter
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   push, push_data         : write request; honoured when not full, or when full with a pop
//   pop                     : read request; honoured when not empty
//   head_data               : entry at the read pointer (meaningless when empty)
//   full, empty, count      : occupancy state, count is $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A pop frees the head slot at this edge, so a full FIFO may also accept a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_console_bridge.sv
// rtl/uart_console_bridge.sv - environment-side endpoint of the SimTop UART console port
//
// Ports:
//   clock, reset                          : rising-edge clock, synchronous active-high reset
//   uart_out_valid, uart_out_ch           : characters emitted by the core, captured into the TX FIFO
//   uart_in_valid, uart_in_ch             : core read request and same-cycle response from the RX FIFO
//   host_tx_valid/ch/ready                : host drain stream of captured characters
//   host_rx_valid/ch/ready                : host fill stream of input characters
//   tx_count, rx_count                    : FIFO occupancies
//   tx_dropped, rx_underflow              : saturating loss / empty-read statistics
module uart_console_bridge
    import uart_console_bridge_pkg::*;
#(
    parameter int                DEPTH   = 16,
    parameter logic [CHAR_W-1:0] NO_CHAR = NO_CHAR_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    uart_out_valid,
    input  logic [CHAR_W-1:0]       uart_out_ch,
    input  logic                    uart_in_valid,
    output logic [CHAR_W-1:0]       uart_in_ch,
    output logic                    host_tx_valid,
    output logic [CHAR_W-1:0]       host_tx_ch,
    input  logic                    host_tx_ready,
    input  logic                    host_rx_valid,
    input  logic [CHAR_W-1:0]       host_rx_ch,
    output logic                    host_rx_ready,
    output logic [$clog2(DEPTH):0]  tx_count,
    output logic [$clog2(DEPTH):0]  rx_count,
    output logic [STAT_W-1:0]       tx_dropped,
    output logic [STAT_W-1:0]       rx_underflow
);

    logic [CHAR_W-1:0] tx_head;
    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic              tx_drop;

    logic [CHAR_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_under;

    // Capture side: a full FIFO still takes the character if the host drains one this cycle.
    assign host_tx_valid = !tx_empty;
    assign host_tx_ch    = tx_empty ? '0 : tx_head;
    assign tx_pop        = !reset && host_tx_valid && host_tx_ready;
    assign tx_push       = !reset && uart_out_valid && (!tx_full || tx_pop);
    assign tx_drop       = !reset && uart_out_valid && !tx_push;

    // Input side: the core only sees entries already stored, so a same-cycle host push is invisible.
    assign host_rx_ready = !rx_full && !reset;
    assign rx_push       = host_rx_valid && host_rx_ready;
    assign uart_in_ch    = rx_empty ? NO_CHAR : rx_head;
    assign rx_pop        = !reset && uart_in_valid && !rx_empty;
    assign rx_under      = !reset && uart_in_valid && rx_empty;

    sync_fifo #(.WIDTH(CHAR_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tx_push),
        .push_data (uart_out_ch),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(.WIDTH(CHAR_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rx_push),
        .push_data (host_rx_ch),
        .pop       (rx_pop),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_dropped   <= '0;
            rx_underflow <= '0;
        end else begin
            tx_dropped   <= sat_inc(tx_dropped, tx_drop);
            rx_underflow <= sat_inc(rx_underflow, rx_under);
        end
    end

endmodule

// File: doc/uart_console_bridge.md
# uart_console_bridge

Environment-side endpoint of the SimTop UART console port. It captures the characters the core emits on `io_uart_out_*` into a capture FIFO and drains them to a host-side valid/ready stream. It also answers the core's per-character read requests on `io_uart_in_*` from a host-filled input FIFO. It sits in the simulation top and bench wrappers next to `SimTop`, replacing the tied-off UART wiring.

## Interface
Parameters:
- `DEPTH`, 16: entries per FIFO; power of two, at least 2.
- `NO_CHAR`, 8'hFF: value returned to the core when the input FIFO is empty.

Ports:
- `clock` in 1: single clock; every register updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `uart_out_valid` in 1: core emits a character this cycle.
- `uart_out_ch` in 8: emitted character.
- `uart_in_valid` in 1: core requests one input character this cycle.
- `uart_in_ch` out 8: response character, valid in the same cycle as the request.
- `host_tx_valid` out 1: a captured character is available.
- `host_tx_ch` out 8: the captured character at the FIFO head.
- `host_tx_ready` in 1: host accepts the captured character.
- `host_rx_valid` in 1: host offers an input character.
- `host_rx_ch` in 8: the offered input character.
- `host_rx_ready` out 1: the input FIFO can take the offered character.
- `tx_count` out clog2(DEPTH)+1: capture FIFO occupancy.
- `rx_count` out clog2(DEPTH)+1: input FIFO occupancy.
- `tx_dropped` out 16: number of emitted characters lost because the capture FIFO was full; saturates.
- `rx_underflow` out 16: number of core requests served while the input FIFO was empty; saturates.

## Operation
- **Capture push:** a character is pushed when `uart_out_valid` is high and the capture FIFO is not full, or when it is full and a host pop happens in the same cycle.
  - Otherwise the character is dropped and `tx_dropped` increments.
- **Capture drain:**
  - `host_tx_valid` = capture FIFO not empty.
  - `host_tx_ch` = head entry, or 8'h00 when empty.
  - A pop happens on `host_tx_valid && host_tx_ready`.
- **Input push:**
  - `host_rx_ready` = input FIFO not full, and low while `reset` is high.
  - A push happens on `host_rx_valid && host_rx_ready`.
  - There is no full-and-pop bypass.
- **Core read:**
  - `uart_in_ch` = input FIFO head when the FIFO is not empty, else `NO_CHAR`; combinational from FIFO state.
  - `uart_in_valid` with a non-empty FIFO pops the head.
  - `uart_in_valid` with an empty FIFO returns `NO_CHAR`, increments `rx_underflow`, and pops nothing.
  - A character pushed by the host in the same cycle is not visible to that request.
- **Counters:** 16-bit and saturating at 16'hFFFF; they never wrap.
- **FIFO pointers:** clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is tracked by a separate counter, so full and empty are unambiguous.
- **While `reset` is high:** all pushes, pops and counter increments are suppressed.

## Timing
- **Reset values after the reset edge:** both FIFOs empty.
  - `host_tx_valid`=0, `host_tx_ch`=8'h00.
  - `uart_in_ch`=`NO_CHAR`.
  - `host_rx_ready`=1 once `reset` is low.
  - `tx_count`=`rx_count`=0, `tx_dropped`=`rx_underflow`=0.
- **Reset mid-operation:** contents are discarded; there is no partial drain.
- **Capture latency:** a character pushed in cycle N appears on `host_tx_*` in cycle N+1.
- **Input latency:** a host push in cycle N is readable by the core in cycle N+1.
- **Response latency:** `uart_in_ch` is zero-latency relative to `uart_in_valid`; the pop takes effect at the next edge.
- **Simultaneous push and pop on the same FIFO:** occupancy is unchanged and both operations complete.
- **Counts:** `tx_count` and `rx_count` are registered and reflect state after the previous edge.

## Structure
- Shared defines file holds:
  - UART character width (8).
  - Default `NO_CHAR`.
  - Statistics counter width (16).
- One sub-module, `sync_fifo`, parameterised by `WIDTH` and `DEPTH`:
  - push/pop, head data, full, empty and count.
  - Synchronous active-high reset.
  - Instantiated twice: capture FIFO and input FIFO.
- The top level adds:
  - the full-with-pop push rule on the capture side;
  - `NO_CHAR` and 8'h00 substitution;
  - the two saturating counters.

## Test plan
- **Reset state:** hold `reset` for 3 cycles, then release → all outputs at their reset values; `host_rx_ready`=1 in the first cycle after release.
- **Capture order:** the core emits 'H','i',8'h0A on consecutive cycles with `host_tx_ready`=1 → `host_tx_ch` shows 'H','i',8'h0A in cycles N+1..N+3; `tx_count` never exceeds 1.
- **Capture overflow:** with `DEPTH`=16 and `host_tx_ready`=0, emit 20 characters → `tx_count`=16 and `tx_dropped`=4. Then emit one more while popping once → no drop and `tx_count` stays 16.
- **Input path:** the host pushes 'a','b'; the core requests three times → responses 'a','b',8'hFF, `rx_underflow`=1, `rx_count` ends at 0.
- **Same-cycle request:** the host pushes 'x' in the same cycle as a core request on an empty FIFO → response 8'hFF; the next request returns 'x'.
- **Saturation and reset:** force 65540 underflows → `rx_underflow`=16'hFFFF. Assert `reset` with both FIFOs half full → the next cycle shows empty FIFOs and zero counters.
